fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Control and pointer manager for the memory_4x8 storage array; together they form one PCIe-switch lane FIFO.
- Converts requester push/pop into memory write/read strobes and wr_ptr/rd_ptr addresses.
- Keeps the occupancy count and produces full/empty/almost-full/almost-empty flags for the downstream arbiter.
- Runs a config/operation/error FSM with programmable thresholds.

Parameters:
MAIN_SIZE, 4, pointer width; DEPTH = 2**MAIN_SIZE (16).
UMBRAL_ALTO_DEF, 12, almost-full threshold loaded at reset.
UMBRAL_BAJO_DEF, 4, almost-empty threshold loaded at reset.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high; clears all state on the next clk edge.
init  in  1  config request; thresholds sampled while in INIT.
umbral_alto  in  MAIN_SIZE+1  almost-full threshold.
umbral_bajo  in  MAIN_SIZE+1  almost-empty threshold.
push  in  1  write request.
pop  in  1  read request.
write  out  1  memory write strobe (combinational).
read  out  1  memory read strobe (combinational).
wr_ptr  out  MAIN_SIZE  memory write address (registered).
rd_ptr  out  MAIN_SIZE  memory read address (registered).
fifo_count  out  MAIN_SIZE+1  occupancy, 0..DEPTH.
full, empty, almost_full, almost_empty  out  1 each  status flags.
error  out  1  sticky overflow/underflow indication.
state  out  5  one-hot FSM state.

Behaviour:
Reset values:
- state=RESET, wr_ptr=rd_ptr=0, fifo_count=0, error=0.
- Thresholds = defaults, so empty=1, almost_empty=1, full=0, almost_full=0.
- Memory contents are not touched.

FSM (one-hot): RESET=5'b00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
- RESET -> INIT unconditionally on the first edge with reset=0.
- INIT: each cycle, alto_q<=umbral_alto and bajo_q<=umbral_bajo.
  - Exit to IDLE when init=0 and the sampled config is valid (bajo < alto <= DEPTH).
  - An invalid config holds INIT.
- IDLE: init=1 -> INIT; else accepted push -> ACTIVE; else stay.
- ACTIVE: init is ignored.
  - Any rejected request (overflow/underflow) -> ERROR.
  - Else fifo_count_next==0 -> IDLE.
- IDLE also goes to ERROR on an underflow.
- ERROR: sticky; error=1; exits only via reset.
- In RESET, INIT and ERROR: write=read=0; push/pop are ignored, not counted as errors.

Acceptance (IDLE/ACTIVE only):
- wr_ok = push & ~full; rd_ok = pop & ~empty.
- write=wr_ok and read=rd_ok in the same cycle as the request, addressing the current wr_ptr/rd_ptr.
- push & full: rejected, overflow. This holds even with a simultaneous pop; the pop is still accepted.
- pop & empty: rejected, underflow. This holds even with a simultaneous push; the push is still accepted.
- Both accepted: fifo_count unchanged; both pointers increment.

Pointers: increment by 1 on acceptance; DEPTH-1 wraps to 0 (natural modulo).

Count:
- Registered: +1 on wr_ok only, -1 on rd_ok only.
- Width MAIN_SIZE+1, range 0..DEPTH; never wraps, by construction.

Flags (combinational from registered count and thresholds):
- full = (count==DEPTH), empty = (count==0).
- almost_full = (count>=alto_q), almost_empty = (count<=bajo_q).

Reset mid-operation: all registers return to reset values on the next edge; in-flight requests are dropped.

Decomposition:
- Package fifo_ctrl_pkg: state one-hot encodings and the DEPTH localparam.
- One natural sub-module, fifo_ptr: MAIN_SIZE-bit wrap counter with enable and synchronous reset, instantiated twice (wr_ptr, rd_ptr).

Test Plan:
- reset 2 cycles; init=1, alto=10, bajo=3 for 2 cycles, then init=0 -> state RESET->INIT->IDLE; empty=1, almost_empty=1, fifo_count=0.
- 16 consecutive pushes from IDLE ->
  - write=1 every cycle; wr_ptr 0..15 then 0; state ACTIVE.
  - almost_empty drops when count=4; almost_full rises at count=10.
  - full=1 after the 16th push.
- Full FIFO, push=1 and pop=1 -> write=0, read=1, rd_ptr+1, count 15; next cycle state=ERROR, error=1; error remains 1 until reset.
- Count=5, push=pop=1 for 3 cycles -> count stays 5; wr_ptr and rd_ptr each advance by 3.
- Empty FIFO in IDLE, pop=1 -> read=0; next cycle state=ERROR, error=1.
- init with alto=3, bajo=5, then init=0 -> state stays INIT.
  - Then reset during ACTIVE at count=7 -> next edge count=0, pointers=0, state=RESET.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the lane FIFO controller: default depth and the
// one-hot encodings of the control state machine.
package fifo_ctrl_pkg;

  localparam int DEPTH = 16;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address counter for one side of the FIFO; advances by one on each
// accepted transfer and rolls over naturally at 2**WIDTH.
module fifo_ptr #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Control and pointer manager for one switch-lane FIFO: turns push/pop into
// memory strobes, tracks occupancy and status flags, and runs the config FSM.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_SIZE       = $clog2(DEPTH),
  parameter int UMBRAL_ALTO_DEF = 12,
  parameter int UMBRAL_BAJO_DEF = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_init,
  input  logic [MAIN_SIZE:0]   i_umbral_alto,
  input  logic [MAIN_SIZE:0]   i_umbral_bajo,
  input  logic                 i_push,
  input  logic                 i_pop,
  output logic                 o_write,
  output logic                 o_read,
  output logic [MAIN_SIZE-1:0] o_wr_ptr,
  output logic [MAIN_SIZE-1:0] o_rd_ptr,
  output logic [MAIN_SIZE:0]   o_fifo_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic                 o_error,
  output logic [4:0]           o_state
);

  localparam logic [MAIN_SIZE:0] CNT_FULL = (MAIN_SIZE+1)'(2**MAIN_SIZE);
  localparam logic [MAIN_SIZE:0] ALTO_RST = (MAIN_SIZE+1)'(UMBRAL_ALTO_DEF);
  localparam logic [MAIN_SIZE:0] BAJO_RST = (MAIN_SIZE+1)'(UMBRAL_BAJO_DEF);

  state_t               r_state;
  state_t               w_state_next;
  logic [MAIN_SIZE:0]   r_count;
  logic [MAIN_SIZE:0]   w_count_next;
  logic [MAIN_SIZE:0]   r_alto_q;
  logic [MAIN_SIZE:0]   r_bajo_q;
  logic                 w_active;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_overflow;
  logic                 w_underflow;
  logic                 w_cfg_valid;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_active = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

  // Requests are only meaningful while operating; elsewhere they are dropped silently.
  assign w_wr_ok     = w_active & i_push & ~w_full;
  assign w_rd_ok     = w_active & i_pop & ~w_empty;
  assign w_overflow  = w_active & i_push & w_full;
  assign w_underflow = w_active & i_pop & w_empty;

  assign w_cfg_valid = (r_bajo_q < r_alto_q) && (r_alto_q <= CNT_FULL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_RESET;
      r_count  <= '0;
      r_alto_q <= ALTO_RST;
      r_bajo_q <= BAJO_RST;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (r_state == ST_INIT) begin
        r_alto_q <= i_umbral_alto;
        r_bajo_q <= i_umbral_bajo;
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_next = r_count + (MAIN_SIZE+1)'(1);
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_next = r_count - (MAIN_SIZE+1)'(1);
    end
  end

  // INIT leaves on the thresholds captured in earlier cycles, not this cycle's inputs.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: w_state_next = ST_INIT;
      ST_INIT: begin
        if (!i_init && w_cfg_valid) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_underflow)  w_state_next = ST_ERROR;
        else if (i_init)  w_state_next = ST_INIT;
        else if (w_wr_ok) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_overflow || w_underflow) w_state_next = ST_ERROR;
        else if (w_count_next == '0)   w_state_next = ST_IDLE;
      end
      ST_ERROR: w_state_next = ST_ERROR;
      default:  w_state_next = ST_RESET;
    endcase
  end

  fifo_ptr #(.WIDTH(MAIN_SIZE)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_wr_ok),
    .o_ptr   (o_wr_ptr)
  );

  fifo_ptr #(.WIDTH(MAIN_SIZE)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_rd_ok),
    .o_ptr   (o_rd_ptr)
  );

  assign o_write        = w_wr_ok;
  assign o_read         = w_rd_ok;
  assign o_fifo_count   = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= r_alto_q);
  assign o_almost_empty = (r_count <= r_bajo_q);
  assign o_error        = (r_state == ST_ERROR);
  assign o_state        = r_state;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based occupancy model is compared
// against the DUT every cycle, with directed scenarios and randomized traffic.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [4:0] umbralAlto = 5'd0;
  logic [4:0] umbralBajo = 5'd0;
  logic       write;
  logic       read;
  logic [3:0] wrPtr;
  logic [3:0] rdPtr;
  logic [4:0] fifoCount;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic       almostEmpty;
  logic       error;
  logic [4:0] state;

  int mState = M_RESET;
  int mq[$];
  int wrTotal = 0;
  int rdTotal = 0;
  int mAlto = 12;
  int mBajo = 4;
  int checkCount = 0;
  int passCount = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_init         (init),
    .i_umbral_alto  (umbralAlto),
    .i_umbral_bajo  (umbralBajo),
    .i_push         (push),
    .i_pop          (pop),
    .o_write        (write),
    .o_read         (read),
    .o_wr_ptr       (wrPtr),
    .o_rd_ptr       (rdPtr),
    .o_fifo_count   (fifoCount),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almostFull),
    .o_almost_empty (almostEmpty),
    .o_error        (error),
    .o_state        (state)
  );

  function automatic logic [4:0] stateCode(input int s);
    case (s)
      M_RESET:  return 5'b00001;
      M_INIT:   return 5'b00010;
      M_IDLE:   return 5'b00100;
      M_ACTIVE: return 5'b01000;
      default:  return 5'b10000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  // Expected outputs follow from occupancy (queue size), transfer totals and thresholds.
  task automatic compareAll();
    int  n;
    bit  act;
    n   = mq.size();
    act = (mState == M_IDLE) || (mState == M_ACTIVE);
    checkOutput("state", 32'(state), 32'(stateCode(mState)));
    checkOutput("wr_ptr", 32'(wrPtr), 32'(wrTotal % DEPTH));
    checkOutput("rd_ptr", 32'(rdPtr), 32'(rdTotal % DEPTH));
    checkOutput("fifo_count", 32'(fifoCount), 32'(n));
    checkBit("full", full, n == DEPTH);
    checkBit("empty", empty, n == 0);
    checkBit("almost_full", almostFull, n >= mAlto);
    checkBit("almost_empty", almostEmpty, n <= mBajo);
    checkBit("error", error, mState == M_ERROR);
    checkBit("write", write, act && push && n < DEPTH);
    checkBit("read", read, act && pop && n > 0);
    if (act && pop && n > 0) checkOutput("rd_addr_order", 32'(rdPtr), 32'(mq[0]));
  endtask

  task automatic modelStep();
    int n;
    bit ok;
    bit wr;
    bit rd;
    bit bad;
    if (reset) begin
      mState = M_RESET;
      mq.delete();
      wrTotal = 0;
      rdTotal = 0;
      mAlto = 12;
      mBajo = 4;
    end else begin
      case (mState)
        M_RESET: mState = M_INIT;
        M_INIT: begin
          ok = !init && (mBajo < mAlto) && (mAlto <= DEPTH);
          mAlto = int'(umbralAlto);
          mBajo = int'(umbralBajo);
          if (ok) mState = M_IDLE;
        end
        M_IDLE, M_ACTIVE: begin
          n   = mq.size();
          wr  = push && (n < DEPTH);
          rd  = pop && (n > 0);
          bad = (push && n == DEPTH) || (pop && n == 0);
          if (rd) begin
            void'(mq.pop_front());
            rdTotal++;
          end
          if (wr) begin
            mq.push_back(wrTotal % DEPTH);
            wrTotal++;
          end
          if (mState == M_IDLE) begin
            if (pop && n == 0) mState = M_ERROR;
            else if (init)     mState = M_INIT;
            else if (wr)       mState = M_ACTIVE;
          end else begin
            if (bad)                mState = M_ERROR;
            else if (mq.size() == 0) mState = M_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ini, input bit ps, input bit pp,
                               input int alto, input int bajo);
    reset = rst;
    init = ini;
    push = ps;
    pop = pp;
    umbralAlto = 5'(alto);
    umbralBajo = 5'(bajo);
    @(negedge clk);
    if (checkEn) compareAll();
    @(posedge clk);
    modelStep();
    checkEn = 1'b1;
    #1;
  endtask

  task automatic configure(input int alto, input int bajo);
    applyStimulus(0, 1, 0, 0, alto, bajo);
    applyStimulus(0, 1, 0, 0, alto, bajo);
    applyStimulus(0, 0, 0, 0, alto, bajo);
  endtask

  initial begin
    int alto;
    int bajo;
    int pushPct;
    int popPct;
    bit ps;
    bit pp;
    bit rst;
    bit safe;

    applyStimulus(1, 0, 0, 0, 10, 3);
    applyStimulus(1, 0, 0, 0, 10, 3);
    checkOutput("pin_reset_state", 32'(state), 32'd1);
    checkOutput("pin_reset_count", 32'(fifoCount), 32'd0);
    checkBit("pin_reset_empty", empty, 1'b1);
    checkBit("pin_reset_almost_empty", almostEmpty, 1'b1);
    checkBit("pin_reset_full", full, 1'b0);
    checkBit("pin_reset_almost_full", almostFull, 1'b0);
    checkBit("pin_reset_error", error, 1'b0);

    configure(10, 3);
    checkOutput("pin_cfg_idle", 32'(state), 32'd4);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 0, 1, 0, 10, 3);
      if (i == 3)  checkBit("pin_ae_at3", almostEmpty, 1'b1);
      if (i == 4)  checkBit("pin_ae_at4", almostEmpty, 1'b0);
      if (i == 9)  checkBit("pin_af_at9", almostFull, 1'b0);
      if (i == 10) checkBit("pin_af_at10", almostFull, 1'b1);
    end
    checkBit("pin_full16", full, 1'b1);
    checkOutput("pin_count16", 32'(fifoCount), 32'd16);
    checkOutput("pin_wrptr_wrap", 32'(wrPtr), 32'd0);
    checkOutput("pin_active", 32'(state), 32'd8);

    applyStimulus(0, 0, 1, 1, 10, 3);
    checkOutput("pin_ovf_count", 32'(fifoCount), 32'd15);
    checkOutput("pin_ovf_rdptr", 32'(rdPtr), 32'd1);
    checkOutput("pin_ovf_state", 32'(state), 32'd16);
    checkBit("pin_ovf_error", error, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, i[0], 1, i[1], 10, 3);
    checkBit("pin_error_sticky", error, 1'b1);

    applyStimulus(1, 0, 0, 0, 10, 3);
    applyStimulus(1, 0, 0, 0, 10, 3);
    configure(10, 3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 10, 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 10, 3);
    checkOutput("pin_pp_count", 32'(fifoCount), 32'd5);
    checkOutput("pin_pp_wrptr", 32'(wrPtr), 32'd8);
    checkOutput("pin_pp_rdptr", 32'(rdPtr), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 10, 3);
    checkOutput("pin_drain_count", 32'(fifoCount), 32'd0);
    checkOutput("pin_drain_idle", 32'(state), 32'd4);
    applyStimulus(0, 0, 0, 1, 10, 3);
    checkOutput("pin_unf_state", 32'(state), 32'd16);
    checkBit("pin_unf_error", error, 1'b1);

    applyStimulus(1, 0, 0, 0, 3, 5);
    applyStimulus(1, 0, 0, 0, 3, 5);
    applyStimulus(0, 1, 0, 0, 3, 5);
    applyStimulus(0, 1, 0, 0, 3, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 3, 5);
    checkOutput("pin_badcfg_init", 32'(state), 32'd2);
    applyStimulus(0, 0, 0, 0, 10, 3);
    applyStimulus(0, 0, 0, 0, 10, 3);
    checkOutput("pin_goodcfg_idle", 32'(state), 32'd4);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 10, 3);
    checkOutput("pin_c7_count", 32'(fifoCount), 32'd7);
    checkOutput("pin_c7_active", 32'(state), 32'd8);
    applyStimulus(1, 0, 1, 1, 10, 3);
    checkOutput("pin_midrst_count", 32'(fifoCount), 32'd0);
    checkOutput("pin_midrst_wrptr", 32'(wrPtr), 32'd0);
    checkOutput("pin_midrst_rdptr", 32'(rdPtr), 32'd0);
    checkOutput("pin_midrst_state", 32'(state), 32'd1);

    // Random episodes: most avoid illegal requests so the FIFO fills deeply.
    for (int ep = 0; ep < 20; ep++) begin
      bajo = $urandom_range(0, 14);
      alto = $urandom_range(bajo + 1, 16);
      pushPct = $urandom_range(30, 80);
      popPct = $urandom_range(20, 70);
      safe = (ep % 4) != 3;
      applyStimulus(1, 0, 0, 0, alto, bajo);
      applyStimulus(1, 0, 0, 0, alto, bajo);
      configure(alto, bajo);
      for (int c = 0; c < 80; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        ps = ($urandom_range(0, 99) < pushPct);
        pp = ($urandom_range(0, 99) < popPct);
        if (safe && mq.size() == DEPTH) ps = 1'b0;
        if (safe && mq.size() == 0) pp = 1'b0;
        applyStimulus(rst, 0, ps, pp, alto, bajo);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
